// File: rtl/sobel_window_gen_if.sv
// rtl/sobel_window_gen_if.sv - grayscale FIFO pop side and window FIFO push side of the window generator
interface sobel_window_gen_if #(
  parameter int DATA_WIDTH = 8
);
  logic                    in_rd_en;
  logic                    in_empty;
  logic [DATA_WIDTH-1:0]   in_dout;
  logic                    out_wr_en;
  logic                    out_full;
  logic [9*DATA_WIDTH-1:0] out_din;
  logic                    frame_done;

  modport master (
    output in_rd_en, out_wr_en, out_din, frame_done,
    input  in_empty, in_dout, out_full
  );

  modport slave (
    input  in_rd_en, out_wr_en, out_din, frame_done,
    output in_empty, in_dout, out_full
  );
endinterface

// File: rtl/sobel_window_gen.sv
// rtl/sobel_window_gen.sv - line-buffered 3x3 window generator feeding the Sobel stage
module sobel_window_gen #(
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540,
  parameter int DATA_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  sobel_window_gen_if.master  bus
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  typedef enum logic {FILL, RUN} state_t;

  state_t state, state_nxt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          hold_valid;
  logic          frame_done_q;

  logic [DATA_WIDTH-1:0] lb0 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] win [3][3];

  logic                  pop;
  logic                  col_end;
  logic                  frame_end;
  logic                  win_ok;
  logic [DATA_WIDTH-1:0] lb_a;
  logic [DATA_WIDTH-1:0] lb_b;

  // Pop is masked during reset so the FIFO never sees a request while we are held.
  assign bus.in_rd_en  = rst & ~bus.in_empty & (~hold_valid | ~bus.out_full);
  assign bus.out_wr_en = hold_valid & ~bus.out_full;
  assign bus.frame_done = frame_done_q;
  assign bus.out_din = {win[0][0], win[0][1], win[0][2],
                        win[1][0], win[1][1], win[1][2],
                        win[2][0], win[2][1], win[2][2]};

  assign pop       = bus.in_rd_en;
  assign col_end   = (col == COL_LAST);
  assign frame_end = col_end && (row == ROW_LAST);
  assign win_ok    = (state == RUN) && (col >= CW'(2));
  assign lb_a      = lb1[col];
  assign lb_b      = lb0[col];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (pop) begin
      case (state)
        FILL: if (col_end && row == RW'(1)) state_nxt = RUN;
        RUN:  if (frame_end) state_nxt = FILL;
        default: state_nxt = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col          <= '0;
      row          <= '0;
      hold_valid   <= 1'b0;
      frame_done_q <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c] <= '0;
        end
      end
    end else begin
      frame_done_q <= pop & frame_end;
      if (pop) begin
        hold_valid <= win_ok;
        col        <= col_end ? '0 : col + CW'(1);
        if (col_end) begin
          row <= (row == ROW_LAST) ? '0 : row + RW'(1);
        end
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= lb_a;
        win[1][2] <= lb_b;
        win[2][2] <= bus.in_dout;
      end else if (bus.out_wr_en) begin
        hold_valid <= 1'b0;
      end
    end
  end

  // Line buffers carry no reset; row/col gating keeps stale entries out of any emitted window.
  always_ff @(posedge clk) begin
    if (pop) begin
      lb1[col] <= lb_b;
      lb0[col] <= bus.in_dout;
    end
  end
endmodule
